// File: rtl/fsm_sw_sequencer_pkg.sv
// Shared types and constants for the LED-FSM switch sequencer: controller states,
// the auto-demo step table and its last index.
package fsm_sw_sequencer_pkg;

   typedef enum logic [1:0] {
      MANUAL = 2'd0,
      DRIVE  = 2'd1,
      CHECK  = 2'd2
   } ctrl_state_t;

   localparam logic [2:0] LAST_STEP = 3'd5;

   // Demo walk from IDLE: st1, st2, st3, st4, back to st3, then IDLE.
   function automatic logic [2:0] rom_code(input logic [2:0] idx);
      logic [2:0] code;
      case (idx)
         3'd0:    code = 3'b001;
         3'd1:    code = 3'b010;
         3'd2:    code = 3'b100;
         3'd3:    code = 3'b111;
         3'd4:    code = 3'b100;
         default: code = 3'b000;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/fsm_sw_sequencer_if.sv
// Board-side and FSM-side signals of the switch sequencer, plus its controller state.
// Handshake: none; sw_out is a level that the driven FSM samples every clock.
interface fsm_sw_sequencer_if;
   import fsm_sw_sequencer_pkg::*;

   logic [2:0]  sw_raw;
   logic        auto_en;
   logic [2:0]  led_fb;
   logic [2:0]  sw_out;
   logic        busy;
   logic [2:0]  step;
   logic        err;
   ctrl_state_t dbg_state;

   modport master (
      input  sw_raw, auto_en, led_fb,
      output sw_out, busy, step, err, dbg_state
   );

   modport slave (
      output sw_raw, auto_en, led_fb,
      input  sw_out, busy, step, err, dbg_state
   );
endinterface

// File: rtl/fsm_sw_sequencer_debounce.sv
// Two-flop synchronizers for the switches and auto_en, plus a shared-counter
// debouncer that accepts a switch value only after DEB_CYCLES stable cycles.
module sw_debounce #(
   parameter int DEB_CYCLES = 1000,
   parameter int CNT_W      = 27
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] sw_raw,
   input  logic       auto_en,
   output logic [2:0] sw_stable,
   output logic       auto_sync
);

   localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);

   logic [2:0]       sw_s1, sw_s2, stable_q;
   logic             au_s1, au_s2;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sw_s1    <= 3'b000;
         sw_s2    <= 3'b000;
         au_s1    <= 1'b0;
         au_s2    <= 1'b0;
         stable_q <= 3'b000;
         cnt      <= '0;
      end else begin
         sw_s1 <= sw_raw;
         sw_s2 <= sw_s1;
         au_s1 <= auto_en;
         au_s2 <= au_s1;
         // sw_s1 != sw_s2 means the synced value changes next cycle, so the run restarts.
         if (sw_s2 == stable_q) begin
            cnt <= '0;
         end else if (cnt == DEB_LAST) begin
            stable_q <= sw_s2;
            cnt      <= '0;
         end else if (sw_s1 != sw_s2) begin
            cnt <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   assign sw_stable = stable_q;
   assign auto_sync = au_s2;

endmodule

// File: rtl/fsm_sw_sequencer.sv
// Drives the LED FSM switch code from debounced board switches (MANUAL) or from a
// looping demo table (AUTO), checking the FSM's LED feedback after every demo step.
module fsm_sw_sequencer
   import fsm_sw_sequencer_pkg::*;
#(
   parameter int DEB_CYCLES   = 1000,
   parameter int DWELL_CYCLES = 100_000_000,
   parameter int CNT_W        = 27
) (
   input  logic                 clk,
   input  logic                 rst_n,
   fsm_sw_sequencer_if.master   bus
);

   localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);

   logic [2:0]       sw_stable;
   logic             auto_sync, auto_prev, auto_rise, abort;
   ctrl_state_t      state, state_n;
   logic [2:0]       step, step_n, snap, snap_n, sw_out_q, sw_out_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic             err, err_n, busy_q;

   sw_debounce #(
      .DEB_CYCLES (DEB_CYCLES),
      .CNT_W      (CNT_W)
   ) u_debounce (
      .clk       (clk),
      .rst_n     (rst_n),
      .sw_raw    (bus.sw_raw),
      .auto_en   (bus.auto_en),
      .sw_stable (sw_stable),
      .auto_sync (auto_sync)
   );

   assign auto_rise = auto_sync & ~auto_prev;
   assign abort     = ~auto_sync | (sw_stable != snap);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= MANUAL;
         step      <= 3'd0;
         cnt       <= '0;
         snap      <= 3'b000;
         err       <= 1'b0;
         sw_out_q  <= 3'b000;
         busy_q    <= 1'b0;
         auto_prev <= 1'b0;
      end else begin
         state     <= state_n;
         step      <= step_n;
         cnt       <= cnt_n;
         snap      <= snap_n;
         err       <= err_n;
         sw_out_q  <= sw_out_n;
         busy_q    <= (state_n != MANUAL);
         auto_prev <= auto_sync;
      end
   end

   always_comb begin
      state_n  = state;
      step_n   = step;
      cnt_n    = cnt;
      snap_n   = snap;
      err_n    = err;
      sw_out_n = sw_out_q;
      case (state)
         MANUAL: begin
            sw_out_n = sw_stable;
            step_n   = 3'd0;
            cnt_n    = '0;
            if (auto_rise) begin
               snap_n  = sw_stable;
               err_n   = 1'b0;
               state_n = DRIVE;
            end
         end
         DRIVE: begin
            if (abort) begin
               state_n = MANUAL;
               step_n  = 3'd0;
               cnt_n   = '0;
            end else begin
               sw_out_n = rom_code(step);
               if (cnt != {CNT_W{1'b1}}) cnt_n = cnt + 1'b1;
               if (cnt == DWELL_LAST) state_n = CHECK;
            end
         end
         CHECK: begin
            // Abort outranks the LED comparison made in this same cycle.
            if (abort) begin
               state_n = MANUAL;
               step_n  = 3'd0;
               cnt_n   = '0;
            end else if (bus.led_fb != rom_code(step)) begin
               err_n   = 1'b1;
               state_n = MANUAL;
               step_n  = 3'd0;
               cnt_n   = '0;
            end else begin
               cnt_n   = '0;
               state_n = DRIVE;
               step_n  = (step == LAST_STEP) ? 3'd0 : step + 3'd1;
            end
         end
         default: state_n = MANUAL;
      endcase
      // Leaving AUTO hands the FSM the debounced switches on the very next cycle.
      if (state_n == MANUAL) sw_out_n = sw_stable;
   end

   assign bus.sw_out    = sw_out_q;
   assign bus.busy      = busy_q;
   assign bus.step      = step;
   assign bus.err       = err;
   assign bus.dbg_state = state;

endmodule

// File: tb/tb_fsm_sw_sequencer.sv
// Directed bench for fsm_sw_sequencer with a behavioural 5-state LED FSM on led_fb.
module tb_fsm_sw_sequencer;
   import fsm_sw_sequencer_pkg::*;

   logic clk;
   logic rst_n;
   logic force_led;
   int   n_assert;
   int   n_fail;

   fsm_sw_sequencer_if bus ();

   fsm_sw_sequencer #(
      .DEB_CYCLES   (4),
      .DWELL_CYCLES (8),
      .CNT_W        (4)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // LED FSM: IDLE-001->st1-010->st2-100->st3-111->st4-100->st3-000->IDLE
   typedef enum logic [2:0] {F_IDLE, F_ST1, F_ST2, F_ST3, F_ST4} fsm_t;
   fsm_t       fsm_q;
   logic [2:0] fsm_led;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) fsm_q <= F_IDLE;
      else begin
         case (fsm_q)
            F_IDLE:  if (bus.sw_out == 3'b001) fsm_q <= F_ST1;
            F_ST1:   if (bus.sw_out == 3'b010) fsm_q <= F_ST2;
            F_ST2:   if (bus.sw_out == 3'b100) fsm_q <= F_ST3;
            F_ST3:   if (bus.sw_out == 3'b111) fsm_q <= F_ST4;
                     else if (bus.sw_out == 3'b000) fsm_q <= F_IDLE;
            F_ST4:   if (bus.sw_out == 3'b100) fsm_q <= F_ST3;
            default: fsm_q <= F_IDLE;
         endcase
      end
   end

   always_comb begin
      fsm_led = 3'b000;
      case (fsm_q)
         F_ST1:   fsm_led = 3'b001;
         F_ST2:   fsm_led = 3'b010;
         F_ST3:   fsm_led = 3'b100;
         F_ST4:   fsm_led = 3'b111;
         default: fsm_led = 3'b000;
      endcase
   end

   assign bus.led_fb = force_led ? 3'b000 : fsm_led;

   logic [2:0] seq [6];
   initial begin
      seq[0] = 3'b001; seq[1] = 3'b010; seq[2] = 3'b100;
      seq[3] = 3'b111; seq[4] = 3'b100; seq[5] = 3'b000;
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
      n_assert++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   initial begin
      n_assert    = 0;
      n_fail      = 0;
      force_led   = 1'b0;
      rst_n       = 1'b0;
      bus.sw_raw  = 3'b000;
      bus.auto_en = 1'b0;

      // Power-on reset
      #1;
      chk("por_sw_out", 8'(bus.sw_out), 8'h0);
      chk("por_busy",   8'(bus.busy),   8'h0);
      chk("por_state",  8'(bus.dbg_state), 8'(MANUAL));
      tick(3);
      rst_n = 1'b1;
      tick(2);

      // Manual path latency 2+4+1
      bus.sw_raw = 3'b010;
      tick(6);
      chk("man_before", 8'(bus.sw_out), 8'h0);
      tick(1);
      chk("man_after",  8'(bus.sw_out), 8'h2);
      // 3-cycle glitch is rejected
      bus.sw_raw = 3'b001;
      tick(3);
      bus.sw_raw = 3'b010;
      tick(10);
      chk("glitch_hold", 8'(bus.sw_out), 8'h2);
      bus.sw_raw = 3'b000;
      tick(10);
      chk("man_zero", 8'(bus.sw_out), 8'h0);

      // Auto loop through all steps and the 5->0 wrap
      bus.auto_en = 1'b1;
      tick(3);
      chk("entry_state", 8'(bus.dbg_state), 8'(DRIVE));
      chk("entry_busy",  8'(bus.busy), 8'h1);
      chk("entry_sw",    8'(bus.sw_out), 8'h0);
      tick(1);
      for (int k = 0; k < 7; k++) begin
         chk($sformatf("auto_sw_%0d", k),   8'(bus.sw_out), 8'(seq[k % 6]));
         chk($sformatf("auto_step_%0d", k), 8'(bus.step),   8'(k % 6));
         chk($sformatf("auto_err_%0d", k),  8'(bus.err),    8'h0);
         tick(7);
         chk($sformatf("auto_chk_state_%0d", k), 8'(bus.dbg_state), 8'(CHECK));
         chk($sformatf("auto_led_%0d", k),       8'(bus.led_fb),    8'(seq[k % 6]));
         tick(1);
         chk($sformatf("auto_hold_%0d", k), 8'(bus.sw_out), 8'(seq[k % 6]));
         tick(1);
      end

      // Asynchronous reset in the middle of AUTO
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_sw_out", 8'(bus.sw_out), 8'h0);
      chk("rst_busy",   8'(bus.busy),   8'h0);
      chk("rst_step",   8'(bus.step),   8'h0);
      chk("rst_err",    8'(bus.err),    8'h0);
      chk("rst_state",  8'(bus.dbg_state), 8'(MANUAL));
      bus.auto_en = 1'b0;
      tick(2);
      rst_n = 1'b1;
      tick(2);

      // LED mismatch during step 2
      bus.auto_en = 1'b1;
      tick(22);
      force_led = 1'b1;
      tick(7);
      chk("mm_state_check", 8'(bus.dbg_state), 8'(CHECK));
      chk("mm_step",        8'(bus.step), 8'h2);
      tick(1);
      chk("mm_err",    8'(bus.err),  8'h1);
      chk("mm_busy",   8'(bus.busy), 8'h0);
      chk("mm_step0",  8'(bus.step), 8'h0);
      chk("mm_sw_out", 8'(bus.sw_out), 8'h0);
      force_led = 1'b0;
      tick(6);
      chk("mm_sticky", 8'(bus.err), 8'h1);
      chk("mm_manual", 8'(bus.dbg_state), 8'(MANUAL));

      // Re-entry clears err on the entry cycle
      bus.auto_en = 1'b0;
      tick(4);
      bus.auto_en = 1'b1;
      tick(3);
      chk("re_err",  8'(bus.err),  8'h0);
      chk("re_busy", 8'(bus.busy), 8'h1);
      chk("re_step", 8'(bus.step), 8'h0);
      tick(8);
      chk("re_led0", 8'(bus.led_fb), 8'h1);
      tick(2);
      chk("re_step1", 8'(bus.step),   8'h1);
      chk("re_sw1",   8'(bus.sw_out), 8'h2);

      // Abort on switch change during step 3
      tick(18);
      bus.sw_raw = 3'b001;
      tick(6);
      chk("ab_state_drive", 8'(bus.dbg_state), 8'(DRIVE));
      chk("ab_step3",       8'(bus.step),   8'h3);
      chk("ab_sw3",         8'(bus.sw_out), 8'h7);
      tick(1);
      chk("ab_state", 8'(bus.dbg_state), 8'(MANUAL));
      chk("ab_step",  8'(bus.step),   8'h0);
      chk("ab_busy",  8'(bus.busy),   8'h0);
      chk("ab_sw",    8'(bus.sw_out), 8'h1);
      chk("ab_err",   8'(bus.err),    8'h0);

      // auto_en drop in CHECK beats a mismatching LED
      bus.auto_en = 1'b0;
      tick(4);
      bus.auto_en = 1'b1;
      tick(5);
      force_led = 1'b1;
      tick(4);
      bus.auto_en = 1'b0;
      tick(2);
      chk("ab2_state_check", 8'(bus.dbg_state), 8'(CHECK));
      tick(1);
      chk("ab2_state", 8'(bus.dbg_state), 8'(MANUAL));
      chk("ab2_err",   8'(bus.err),  8'h0);
      chk("ab2_busy",  8'(bus.busy), 8'h0);
      chk("ab2_sw",    8'(bus.sw_out), 8'h1);
      force_led = 1'b0;
      tick(3);
      chk("ab2_err_late", 8'(bus.err), 8'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
